// File: rtl/servant_wdt.sv
// Watchdog + SoC reset sequencer; SERVANT_WDT_LOCK_EN makes EN sticky once armed.
// Bus: 1-cycle registered ack, at most one ack per 2 cycles, never stalls; HOLD accesses are acked without effect.
module servant_wdt #(
    parameter int RST_CYCLES = 16,
    parameter int TIMEOUT_W  = 24
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_soc_rst,
    output logic        o_wdt_fired
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 en_q, en_d;
    logic                 cause_q, cause_d;
    logic                 ack_q, ack_d;
    logic                 fired_q, fired_d;
    logic [TIMEOUT_W-1:0] reload_q, reload_d;
    logic [TIMEOUT_W-1:0] count_q, count_d;
    logic [31:0]          rdt_q, rdt_d;

    logic        acc;
    logic        wr_ctrl;
    logic        kick;
    logic        ctrl_en;
    logic [31:0] rd_val;
    logic        unused_dat;

    assign acc     = i_wb_cyc & ~ack_q;
    assign wr_ctrl = acc & i_wb_we & ~i_wb_adr & (state_q == RUN);
    assign kick    = acc & i_wb_we &  i_wb_adr & (state_q == RUN);

`ifdef SERVANT_WDT_LOCK_EN
    assign ctrl_en = en_q | i_wb_dat[0];
`else
    assign ctrl_en = i_wb_dat[0];
`endif

    assign unused_dat = ^i_wb_dat;

    always_comb begin
        rd_val = '0;
        if (i_wb_adr) begin
            rd_val = 32'(count_q);
        end else begin
            rd_val[0] = en_q;
            rd_val[8] = cause_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        en_d     = en_q;
        cause_d  = cause_q;
        reload_d = reload_q;
        count_d  = count_q;
        fired_d  = 1'b0;
        ack_d    = acc;
        rdt_d    = acc ? rd_val : '0;

        case (state_q)
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            RUN: begin
                // Firing wins over any CTRL write; only a kick can rescue a zero count.
                if (en_q && (count_q == '0) && !kick) begin
                    state_d = HOLD;
                    hold_d  = HOLD_INIT;
                    en_d    = 1'b0;
                    cause_d = 1'b1;
                    fired_d = 1'b1;
                end else begin
                    if (kick) begin
                        reload_d = i_wb_dat[TIMEOUT_W-1:0];
                        count_d  = i_wb_dat[TIMEOUT_W-1:0];
                    end else if (wr_ctrl && !en_q && i_wb_dat[0]) begin
                        count_d = reload_q;
                    end else if (en_q) begin
                        count_d = count_q - 1'b1;
                    end
                    if (wr_ctrl) begin
                        en_d = ctrl_en;
                    end
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q  <= HOLD;
            hold_q   <= HOLD_INIT;
            en_q     <= 1'b0;
            cause_q  <= 1'b0;
            reload_q <= '1;
            count_q  <= '1;
            ack_q    <= 1'b0;
            rdt_q    <= '0;
            fired_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            en_q     <= en_d;
            cause_q  <= cause_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            fired_q  <= fired_d;
        end
    end

    assign o_soc_rst   = (state_q == HOLD);
    assign o_wdt_fired = fired_q;
    assign o_wb_ack    = ack_q;
    assign o_wb_rdt    = rdt_q;

endmodule

// File: doc/servant_wdt.md
# servant_wdt

Watchdog and SoC reset sequencer for the servant SoC. It sits between the top-level power-on reset flop and the servant core. It stretches the power-on reset into a fixed-length SoC reset, and it re-asserts that reset whenever a software-armed countdown expires without being kicked. Software controls it through a small single-slave Wishbone register window.

## Interface
Parameters:
- RST_CYCLES, 16: number of cycles o_soc_rst stays high after any reset cause clears; legal range ≥1.
- TIMEOUT_W, 24: width of the watchdog counter and reload register; legal range 1..32.

Ports:
- i_wb_clk  in  1: the single clock; all logic is on its rising edge.
- i_wb_rst  in  1: synchronous, active-high reset, driven by the power-on reset flop.
- i_wb_cyc  in  1: bus cycle request.
- i_wb_we  in  1: write enable.
- i_wb_adr  in  1: word select; 0 = CTRL, 1 = TIMER.
- i_wb_dat  in  32: write data.
- o_wb_rdt  out  32: read data, valid while o_wb_ack is high.
- o_wb_ack  out  1: single-cycle acknowledge.
- o_soc_rst  out  1: active-high reset to the servant core.
- o_wdt_fired  out  1: one-cycle pulse on watchdog expiry.

## Operation
- State on i_wb_rst:
  - state = HOLD, hold = RST_CYCLES-1.
  - EN = 0, CAUSE = 0, reload = all ones, count = all ones.
  - Outputs: o_soc_rst = 1, o_wdt_fired = 0, o_wb_ack = 0, o_wb_rdt = 0.
- HOLD state:
  - o_soc_rst = 1.
  - hold decrements each cycle.
  - When hold == 0, next state is RUN.
- RUN state:
  - o_soc_rst = 0.
  - If EN = 1, count decrements by 1 per cycle.
  - If EN = 1, count == 0 and there is no kick this cycle, the watchdog fires. Next cycle: state = HOLD, hold = RST_CYCLES-1, EN = 0, CAUSE = 1, o_wdt_fired = 1 for exactly one cycle.
  - If EN = 0, count holds.
- CTRL register (adr 0):
  - Read: bit 0 = EN, bit 8 = CAUSE, all other bits 0.
  - Write: bit 0 → EN. An EN 0→1 transition also loads count from reload. CAUSE is read-only.
  - CAUSE is cleared only by i_wb_rst.
- TIMER register (adr 1):
  - Write (kick): reload ← i_wb_dat[TIMEOUT_W-1:0] and count ← the same value, in the same cycle.
  - Read: current count, zero-extended.
- Bus rules:
  - o_wb_ack is asserted the cycle after i_wb_cyc is sampled high. It is deasserted the following cycle, even if cyc is still high; that is, ack = cyc & ~ack, registered.
  - Write side effects take effect at the edge that raises o_wb_ack.
  - o_wb_rdt is registered alongside ack and is 0 when ack is low.
  - Accesses during HOLD are acked but have no effect. Reads during HOLD return the true values.
- Simultaneous events:
  - A kick in the cycle where count == 0 reloads the counter and suppresses firing.
  - A kick of 0 with EN = 1 fires on the next RUN cycle.
  - i_wb_rst overrides everything, including a fire in progress and an in-flight ack.

## Timing
- From i_wb_rst deasserted (first edge sampling it low), o_soc_rst stays high for exactly RST_CYCLES further cycles.
- Expiry to reset: o_soc_rst rises on the edge after count == 0 is sampled.
- After that, o_soc_rst stays high for RST_CYCLES cycles.
- o_wdt_fired is coincident with the first cycle of that high period.
- Bus latency is 1 cycle, with at most one ack per 2 cycles.
- Counter underflow cannot occur, because firing takes precedence at 0.

## Configuration
- Macro: SERVANT_WDT_LOCK_EN.
- Defined:
  - Once EN = 1, CTRL writes with bit 0 = 0 are ignored.
  - EN returns to 0 only via firing or i_wb_rst.
  - Kicks still work.
- Undefined: EN is freely writable, so software may disarm the watchdog.

## Test plan
- **Power-on:** assert i_wb_rst for 3 cycles with RST_CYCLES = 16. Expect o_soc_rst = 1 through the reset and for 16 cycles after, then 0. Expect a CTRL read to return 0x0.
- **Expiry:** write TIMER = 10, then CTRL = 1. Expect count to reach 0 and o_wdt_fired to pulse once. Expect o_soc_rst high for 16 cycles. Afterwards expect a CTRL read to return 0x100 (EN = 0, CAUSE = 1).
- **Kick race:** with EN = 1, write TIMER = 5 in the exact cycle count == 0. Expect no fire, and a readback of count ≤ 5 that decrements.
- **Bus protocol:** hold i_wb_cyc high for 4 cycles on a TIMER read. Expect ack pattern 0,1,0,1. Expect o_wb_rdt = 0 while ack is low.
- **Lock:** with SERVANT_WDT_LOCK_EN defined, write CTRL = 1 then CTRL = 0. Expect EN to read 1 and the watchdog still to fire. Without the macro, expect EN to read 0 and no fire.
- **Reset mid-operation:** assert i_wb_rst during HOLD after a fire. Expect CAUSE = 0, EN = 0 and hold restarted, so o_soc_rst stays high for 16 cycles after the release.
